swin_lbuf_gen: RTL and testbench

SWIN_LBUF_GEN -- requirements
Module: swin_lbuf_gen

---
 rtl/swin_pkg.sv | 14 +
 rtl/swin_line_ram.sv | 30 +++
 rtl/swin_lbuf_gen.sv | 176 +++++++++++++++++
 tb/tb_swin_lbuf_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swin_pkg.sv
// Shared defaults and pad-mode encoding for the sliding-window line buffer.
package swin_pkg;

  localparam int unsigned DEF_PIX_W          = 8;
  localparam int unsigned DEF_PIX_PER_WORD   = 16;
  localparam int unsigned DEF_WIN_ROWS       = 3;
  localparam int unsigned DEF_MAX_LINE_WORDS = 64;

  typedef enum logic {
    PAD_DROP = 1'b0,
    PAD_ZERO = 1'b1
  } pad_mode_e;

endpackage

// File: rtl/swin_line_ram.sv
// Single-port line memory: read-first, registered read, separate read/write enables.
module swin_line_ram #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              ren,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Both accesses sample the same pre-edge array, so a same-address read returns old data.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem_q[addr] <= wdata;
    end
    if (ren) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/swin_lbuf_gen.sv
// Sliding K-row column-window generator: K-1 line banks plus the live row, one-word output reg.
module swin_lbuf_gen
  import swin_pkg::*;
#(
  parameter int unsigned PIX_W          = DEF_PIX_W,
  parameter int unsigned PIX_PER_WORD   = DEF_PIX_PER_WORD,
  parameter int unsigned WIN_ROWS       = DEF_WIN_ROWS,
  parameter int unsigned MAX_LINE_WORDS = DEF_MAX_LINE_WORDS,
  localparam int unsigned WORD_W        = PIX_W * PIX_PER_WORD,
  localparam int unsigned ADDR_W        = $clog2(MAX_LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W:0]              cfg_line_words,
  input  logic                         cfg_pad_mode,
  input  logic [WORD_W-1:0]            data_in,
  input  logic                         data_in_sof,
  input  logic                         data_in_vld,
  output logic                         data_in_rdy,
  output logic [WIN_ROWS*WORD_W-1:0]   data_out,
  output logic                         data_out_sol,
  output logic                         data_out_eol,
  output logic                         data_out_vld,
  input  logic                         data_out_rdy
);

  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned NB     = WIN_ROWS - 1;
  localparam int unsigned BANK_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned ROW_W  = $clog2(WIN_ROWS);

  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_LINE_WORDS);
  localparam logic [ROW_W-1:0]  ROW_FULL  = ROW_W'(WIN_ROWS - 1);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NB - 1);

  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] v);
    return ((v == '0) || (v > MAX_LEN)) ? MAX_LEN : v;
  endfunction

  function automatic logic [BANK_W-1:0] bank_idx(input logic [BANK_W-1:0] base, input int i);
    return BANK_W'((int'(base) + i) % int'(NB));
  endfunction

  logic [LEN_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [LEN_W-1:0]  len_q, len_d;
  pad_mode_e         pad_q, pad_d;

  logic              vld_q, vld_d;
  logic              sol_q, sol_d;
  logic              eol_q, eol_d;
  logic [BANK_W-1:0] sel_q, sel_d;
  logic [WORD_W-1:0] cur_q, cur_d;
  logic [NB-1:0]     zero_q, zero_d;

  logic              accept;
  logic              sof_acc;
  logic [LEN_W-1:0]  eff_col;
  logic [ROW_W-1:0]  eff_row;
  logic [BANK_W-1:0] eff_bank;
  logic [LEN_W-1:0]  eff_len;
  pad_mode_e         eff_pad;
  logic              wrap;

  logic [WORD_W-1:0] ram_rdata [NB];

  assign data_in_rdy = ~vld_q | data_out_rdy;
  assign accept      = data_in_vld & data_in_rdy;
  assign sof_acc     = accept & data_in_sof;

  // An accepted sof word restarts the frame and picks up fresh config for itself.
  assign eff_col  = sof_acc ? '0 : col_q;
  assign eff_row  = sof_acc ? '0 : row_q;
  assign eff_bank = sof_acc ? '0 : bank_q;
  assign eff_len  = sof_acc ? sat_len(cfg_line_words) : len_q;
  assign eff_pad  = sof_acc ? pad_mode_e'(cfg_pad_mode) : pad_q;
  assign wrap     = (eff_col == eff_len - LEN_W'(1));

  for (genvar b = 0; b < NB; b++) begin : g_bank
    swin_line_ram #(
      .WIDTH (WORD_W),
      .DEPTH (MAX_LINE_WORDS),
      .ADDR_W(ADDR_W)
    ) u_ram (
      .clk  (clk),
      .ren  (accept),
      .wen  (accept && (eff_bank == BANK_W'(b))),
      .addr (eff_col[ADDR_W-1:0]),
      .wdata(data_in),
      .rdata(ram_rdata[b])
    );
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    bank_d = bank_q;
    len_d  = len_q;
    pad_d  = pad_q;
    vld_d  = vld_q;
    sol_d  = sol_q;
    eol_d  = eol_q;
    sel_d  = sel_q;
    cur_d  = cur_q;
    zero_d = zero_q;
    if (accept) begin
      len_d = eff_len;
      pad_d = eff_pad;
      if (wrap) begin
        col_d  = '0;
        bank_d = (eff_bank == BANK_LAST) ? '0 : eff_bank + BANK_W'(1);
        row_d  = (eff_row == ROW_FULL) ? eff_row : eff_row + ROW_W'(1);
      end else begin
        col_d  = eff_col + LEN_W'(1);
        bank_d = eff_bank;
        row_d  = eff_row;
      end
      vld_d = (eff_pad == PAD_ZERO) || (eff_row == ROW_FULL);
      sol_d = (eff_col == '0);
      eol_d = wrap;
      sel_d = eff_bank;
      cur_d = data_in;
      // Slice i holds a row that exists only once row_cnt has reached K-1-i.
      for (int i = 0; i < int'(NB); i++) begin
        zero_d[i] = int'(eff_row) < (int'(NB) - i);
      end
    end else if (data_out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      bank_q <= '0;
      len_q  <= sat_len(cfg_line_words);
      pad_q  <= pad_mode_e'(cfg_pad_mode);
      vld_q  <= 1'b0;
      sol_q  <= 1'b0;
      eol_q  <= 1'b0;
      sel_q  <= '0;
      cur_q  <= '0;
      zero_q <= '1;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      bank_q <= bank_d;
      len_q  <= len_d;
      pad_q  <= pad_d;
      vld_q  <= vld_d;
      sol_q  <= sol_d;
      eol_q  <= eol_d;
      sel_q  <= sel_d;
      cur_q  <= cur_d;
      zero_q <= zero_d;
    end
  end

  // Bank outputs only change on accept, so the window holds during a stall.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < int'(NB); i++) begin
      if (!zero_q[i]) begin
        data_out[i*WORD_W +: WORD_W] = ram_rdata[bank_idx(sel_q, i)];
      end
    end
    data_out[NB*WORD_W +: WORD_W] = cur_q;
  end

  assign data_out_vld = vld_q;
  assign data_out_sol = sol_q;
  assign data_out_eol = eol_q;

endmodule

// File: tb/tb_swin_lbuf_gen.sv
// Directed, table-driven bench for swin_lbuf_gen (K=3 and K=5 instances).
module tb_swin_lbuf_gen;

  localparam int unsigned WW = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [6:0]      a_len;
  logic            a_pad;
  logic [WW-1:0]   a_in;
  logic            a_sof, a_vld, a_rdy;
  logic [3*WW-1:0] a_out;
  logic            a_sol, a_eol, a_ovld, a_ordy;

  logic [6:0]      b_len;
  logic            b_pad;
  logic [WW-1:0]   b_in;
  logic            b_sof, b_vld, b_rdy;
  logic [5*WW-1:0] b_out;
  logic            b_sol, b_eol, b_ovld, b_ordy;

  int checks   = 0;
  int failures = 0;

  swin_lbuf_gen dut3 (
    .clk           (clk),
    .rst           (rst),
    .cfg_line_words(a_len),
    .cfg_pad_mode  (a_pad),
    .data_in       (a_in),
    .data_in_sof   (a_sof),
    .data_in_vld   (a_vld),
    .data_in_rdy   (a_rdy),
    .data_out      (a_out),
    .data_out_sol  (a_sol),
    .data_out_eol  (a_eol),
    .data_out_vld  (a_ovld),
    .data_out_rdy  (a_ordy)
  );

  swin_lbuf_gen #(.WIN_ROWS(5)) dut5 (
    .clk           (clk),
    .rst           (rst),
    .cfg_line_words(b_len),
    .cfg_pad_mode  (b_pad),
    .data_in       (b_in),
    .data_in_sof   (b_sof),
    .data_in_vld   (b_vld),
    .data_in_rdy   (b_rdy),
    .data_out      (b_out),
    .data_out_sol  (b_sol),
    .data_out_eol  (b_eol),
    .data_out_vld  (b_ovld),
    .data_out_rdy  (b_ordy)
  );

  typedef struct {
    logic [7:0] w;
    logic       sof;
    logic       vld;
    logic [7:0] s0, s1, s2;
    logic       sol, eol;
  } vec_t;

  vec_t tbl [16];

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_win3(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic esol, input logic eeol);
    logic [WW-1:0] x0, x1, x2;
    x0 = a_out[0*WW +: WW];
    x1 = a_out[1*WW +: WW];
    x2 = a_out[2*WW +: WW];
    checks++;
    if (x0 !== WW'(e0) || x1 !== WW'(e1) || x2 !== WW'(e2) || a_sol !== esol ||
        a_eol !== eeol) begin
      failures++;
      $display("FAIL %s: got {%h,%h,%h} sol=%b eol=%b want {%h,%h,%h} sol=%b eol=%b", nm,
               x0, x1, x2, a_sol, a_eol, e0, e1, e2, esol, eeol);
    end
  endtask

  task automatic do_reset(input logic [6:0] len, input logic pad);
    @(negedge clk);
    rst = 1'b1; a_len = len; a_pad = pad; a_vld = 1'b0; a_sof = 1'b0; a_ordy = 1'b1;
    b_len = 7'd1; b_pad = 1'b0; b_vld = 1'b0; b_sof = 1'b0; b_ordy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push3(input logic [7:0] w, input logic sof);
    @(negedge clk);
    a_in = WW'(w); a_sof = sof; a_vld = 1'b1;
    #1;
    chk_bit($sformatf("in_rdy_w%0d", w), a_rdy, 1'b1);
    @(posedge clk);
    #1;
    a_vld = 1'b0; a_sof = 1'b0;
  endtask

  task automatic push5(input logic [7:0] w);
    @(negedge clk);
    b_in = WW'(w); b_sof = 1'b0; b_vld = 1'b1;
    @(posedge clk);
    #1;
    b_vld = 1'b0;
  endtask

  task automatic run_table3(input logic pad, input logic first_sof);
    int nout;
    for (int k = 0; k < 16; k++) begin
      int w, r, c;
      w = k + 1; r = k / 4; c = k % 4;
      tbl[k] = '{w: 8'(w), sof: first_sof && (k == 0), vld: pad || (r >= 2),
                 s0: (r >= 2) ? 8'(w - 8) : 8'h00, s1: (r >= 1) ? 8'(w - 4) : 8'h00,
                 s2: 8'(w), sol: (c == 0), eol: (c == 3)};
    end
    nout = 0;
    for (int k = 0; k < 16; k++) begin
      push3(tbl[k].w, tbl[k].sof);
      chk_bit($sformatf("tbl_p%0d_vld_w%0d", pad, k + 1), a_ovld, tbl[k].vld);
      if (a_ovld) nout++;
      if (tbl[k].vld) begin
        chk_win3($sformatf("tbl_p%0d_win_w%0d", pad, k + 1), tbl[k].s0, tbl[k].s1, tbl[k].s2,
                 tbl[k].sol, tbl[k].eol);
      end
    end
    chk_int($sformatf("tbl_p%0d_count", pad), nout, pad ? 16 : 8);
  endtask

  initial begin
    rst = 1'b0;
    a_in = '0; a_sof = 1'b0; a_vld = 1'b0; a_ordy = 1'b1; a_len = 7'd4; a_pad = 1'b0;
    b_in = '0; b_sof = 1'b0; b_vld = 1'b0; b_ordy = 1'b1; b_len = 7'd1; b_pad = 1'b0;

    // Reset state
    do_reset(7'd4, 1'b0);
    #1;
    chk_bit("rst_vld", a_ovld, 1'b0);
    chk_bit("rst_sol", a_sol, 1'b0);
    chk_bit("rst_eol", a_eol, 1'b0);
    chk_bit("rst_data_zero", (a_out == '0), 1'b1);
    chk_bit("rst_in_rdy", a_rdy, 1'b1);

    // Drop and zero-pad top rows
    run_table3(1'b0, 1'b1);
    do_reset(7'd4, 1'b1);
    run_table3(1'b1, 1'b1);

    // Output backpressure, rdy toggling every cycle
    begin
      int idx, nout, w;
      logic hold;
      logic [3*WW+1:0] snap;
      do_reset(7'd4, 1'b0);
      idx = 0; nout = 0;
      for (int cyc = 0; cyc < 200 && nout < 8; cyc++) begin
        logic acc;
        @(negedge clk);
        a_vld = (idx < 16); a_in = WW'(idx + 1); a_sof = (idx == 0); a_ordy = cyc[0];
        #1;
        acc = a_vld & a_rdy;
        if (a_ovld & a_ordy) begin
          w = 9 + nout;
          chk_win3($sformatf("bp_win%0d", nout), 8'(w - 8), 8'(w - 4), 8'(w),
                   (w == 9) || (w == 13), (w == 12) || (w == 16));
          nout++;
        end
        hold = a_ovld & ~a_ordy;
        snap = {a_out, a_sol, a_eol};
        @(posedge clk);
        #1;
        if (hold) begin
          chk_bit($sformatf("bp_hold_c%0d", cyc), (a_ovld === 1'b1) && ({a_out, a_sol, a_eol}
                  === snap), 1'b1);
        end
        if (acc) idx++;
      end
      a_vld = 1'b0; a_sof = 1'b0; a_ordy = 1'b1;
      chk_int("bp_count", nout, 8);
      chk_int("bp_accepted", idx, 16);
    end

    // K=5, line_len=1
    do_reset(7'd4, 1'b0);
    for (int w = 1; w <= 6; w++) begin
      push5(8'(w));
      chk_bit($sformatf("k5_vld_w%0d", w), b_ovld, (w >= 5));
      if (w >= 5) begin
        checks++;
        if (b_out !== {WW'(w), WW'(w - 1), WW'(w - 2), WW'(w - 3), WW'(w - 4)} ||
            b_sol !== 1'b1 || b_eol !== 1'b1) begin
          failures++;
          $display("FAIL k5_win_w%0d: got %h sol=%b eol=%b want slices %0d..%0d sol=1 eol=1",
                   w, b_out, b_sol, b_eol, w - 4, w);
        end
      end
    end

    // Mid-line sof, pad=1: window for word 6 intact, word 7 restarts at row 0
    do_reset(7'd4, 1'b1);
    for (int w = 1; w <= 6; w++) push3(8'(w), (w == 1));
    chk_win3("sof_p1_w6", 8'h00, 8'h02, 8'h06, 1'b0, 1'b0);
    push3(8'd7, 1'b1);
    chk_bit("sof_p1_w7_vld", a_ovld, 1'b1);
    chk_win3("sof_p1_w7", 8'h00, 8'h00, 8'h07, 1'b1, 1'b0);

    // Mid-line sof, pad=0: silent for 8 further words
    begin
      int nout;
      do_reset(7'd4, 1'b0);
      for (int w = 1; w <= 6; w++) push3(8'(w), (w == 1));
      nout = 0;
      for (int w = 7; w <= 14; w++) begin
        push3(8'(w), (w == 7));
        if (a_ovld) nout++;
      end
      chk_int("sof_p0_silent", nout, 0);
      push3(8'd15, 1'b0);
      chk_bit("sof_p0_w15_vld", a_ovld, 1'b1);
      chk_win3("sof_p0_w15", 8'd7, 8'd11, 8'd15, 1'b1, 1'b0);
    end

    // sof re-latches line length
    do_reset(7'd4, 1'b0);
    for (int w = 1; w <= 6; w++) push3(8'(w), (w == 1));
    a_len = 7'd2;
    for (int w = 7; w <= 10; w++) begin
      push3(8'(w), (w == 7));
      chk_bit($sformatf("relatch_vld_w%0d", w), a_ovld, 1'b0);
    end
    push3(8'd11, 1'b0);
    chk_win3("relatch_w11", 8'd7, 8'd9, 8'd11, 1'b1, 1'b0);
    push3(8'd12, 1'b0);
    chk_win3("relatch_w12", 8'd8, 8'd10, 8'd12, 1'b0, 1'b1);

    // Reset while output is stalled
    do_reset(7'd4, 1'b1);
    push3(8'h55, 1'b1);
    chk_bit("rst_mid_vld_pre", a_ovld, 1'b1);
    @(negedge clk);
    a_ordy = 1'b0;
    @(posedge clk);
    #1;
    chk_bit("rst_mid_hold", a_ovld, 1'b1);
    @(negedge clk);
    rst = 1'b1; a_pad = 1'b0;
    @(posedge clk);
    #1;
    chk_bit("rst_mid_vld", a_ovld, 1'b0);
    chk_bit("rst_mid_in_rdy", a_rdy, 1'b1);
    @(negedge clk);
    rst = 1'b0; a_ordy = 1'b1;
    run_table3(1'b0, 1'b0);

    // cfg_line_words=0 latches as the maximum line length
    do_reset(7'd0, 1'b1);
    for (int w = 1; w <= 65; w++) begin
      push3(8'(w), 1'b0);
      if (w == 63) chk_bit("len0_eol_w63", a_eol, 1'b0);
      if (w == 64) begin
        chk_bit("len0_eol_w64", a_eol, 1'b1);
        chk_bit("len0_sol_w64", a_sol, 1'b0);
      end
      if (w == 65) chk_bit("len0_sol_w65", a_sol, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
